// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, coefficient tables and
// arithmetic helpers for the decimation anti-aliasing FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_e;

  localparam int SAT_W = 128;

  // Q1.15 windowed-sinc low-pass for M=4, taps sum to 32768
  localparam int LP16 [16] = '{
    -80, -300, -560, -320, 1100, 3700, 5600, 7244,
    7244, 5600, 3700, 1100, -320, -560, -300, -80
  };

  localparam int SAT16 [16] = '{default: 32767};

  function automatic int acc_w(
    input int n,
    input int c,
    input int t
  );
    return n + c + $clog2(t);
  endfunction

  function automatic int coef(
    input int set,
    input int t,
    input int c,
    input int k
  );
    if (set == 1) begin
      if (t == 16 && c == 16) return SAT16[k];
      return (1 << (c - 1)) - 1;
    end
    if (t == 16 && c == 16) return LP16[k];
    // other geometries fall back to a unity-gain boxcar
    return (1 << (c - 1)) / t;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat(
    input logic signed [SAT_W-1:0] v,
    input int                      n
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (n - 1)) - one;
    lo  = -(one <<< (n - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered multiplier feeding a clearable
// accumulator; sum_o folds in the product still in flight.
module fir_mac #(
  parameter int N  = 16,
  parameter int C  = 16,
  parameter int AW = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [N-1:0]  x_i,
  input  logic signed [C-1:0]  h_i,
  output logic signed [AW-1:0] sum_o
);

  localparam int PW = N + C;

  logic signed [PW-1:0] prod_q;
  logic signed [PW-1:0] prod_d;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;

  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    if (clr_i) begin
      prod_d = '0;
      acc_d  = '0;
    end else if (en_i) begin
      prod_d = PW'(x_i) * PW'(h_i);
      acc_d  = acc_q + AW'(prod_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign sum_o = acc_q + AW'(prod_q);

endmodule

// File: rtl/fir_decim_lpf.sv
// fir_decim_lpf: time-shared single-MAC low-pass FIR ahead
// of the downsampler; one rounded, saturated output per input.
module fir_decim_lpf
  import fir_pkg::*;
#(
  parameter int N        = 16,
  parameter int T        = 16,
  parameter int C        = 16,
  parameter int COEF_SET = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] sample,
  input  logic                sample_valid,
  output logic                ready,
  output logic signed [N-1:0] sample_out,
  output logic                out_valid,
  output logic                overrun
);

  localparam int KW = $clog2(T);
  localparam int AW = acc_w(N, C, T);
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (C - 2);

  state_e state_q, state_d;

  logic [KW-1:0]       k_q, k_d;
  logic signed [N-1:0] dly_q [T];
  logic signed [N-1:0] dly_d [T];
  logic signed [N-1:0] out_q, out_d;
  logic                vld_q, vld_d;
  logic                ovr_q, ovr_d;

  logic signed [C-1:0]  rom [T];
  logic                 mac_clr;
  logic                 mac_en;
  logic signed [AW-1:0] mac_sum;
  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] shv;

  for (genvar i = 0; i < T; i++) begin : g_rom
    localparam logic signed [C-1:0] HV =
      C'(coef(COEF_SET, T, C, i));
    assign rom[i] = HV;
  end

  fir_mac #(
    .N  (N),
    .C  (C),
    .AW (AW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .x_i   (dly_q[k_q]),
    .h_i   (rom[k_q]),
    .sum_o (mac_sum)
  );

  assign rnd = mac_sum + HALF;
  assign shv = rnd >>> (C - 1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dly_d   = dly_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    ovr_d   = ovr_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    if (sample_valid && state_q != S_IDLE) ovr_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          dly_d[0] = sample;
          for (int i = 1; i < T; i++) dly_d[i] = dly_q[i-1];
          mac_clr = 1'b1;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + 1'b1;
        if (k_q == KW'(T - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        out_d   = N'(sat(SAT_W'(shv), N));
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dly_q   <= '{default: '0};
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dly_q   <= dly_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign sample_out = out_q;
  assign out_valid  = vld_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_fir_decim_lpf.sv
// tb_fir_decim_lpf: scoreboard bench driving a low-pass and a
// saturation-set instance from one shared stimulus stream.
module tb_fir_decim_lpf;

  localparam int N   = 16;
  localparam int T   = 16;
  localparam int C   = 16;
  localparam int LAT = T + 1;

  // round-half-up of h[k]/2 for the Q1.15 low-pass table
  localparam int IMP [16] = '{
    -40, -150, -280, -160, 550, 1850, 2800, 3622,
    3622, 2800, 1850, 550, -160, -280, -150, -40
  };

  typedef struct {
    bit chk;
    int val;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [N-1:0] sample = '0;
  logic sample_valid = 1'b0;

  logic rdy0, rdy1, v0, v1, ov0, ov1;
  logic signed [N-1:0] o0, o1;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nv0   = 0;
  int nv1   = 0;

  fir_decim_lpf #(
    .N(N), .T(T), .C(C), .COEF_SET(0)
  ) u0 (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .ready        (rdy0),
    .sample_out   (o0),
    .out_valid    (v0),
    .overrun      (ov0)
  );

  fir_decim_lpf #(
    .N(N), .T(T), .C(C), .COEF_SET(1)
  ) u1 (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .ready        (rdy1),
    .sample_out   (o1),
    .out_valid    (v1),
    .overrun      (ov1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic score(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (v0) begin
      nv0++;
      if (q0.size() == 0) begin
        score("unexpected_out0", int'(o0), 99999);
      end else begin
        e = q0.pop_front();
        score("lat0", cyc, e.t);
        if (e.chk) score("out0", int'(o0), e.val);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (v1) begin
      nv1++;
      if (q1.size() == 0) begin
        score("unexpected_out1", int'(o1), 99999);
      end else begin
        e = q1.pop_front();
        score("lat1", cyc, e.t);
        if (e.chk) score("out1", int'(o1), e.val);
      end
    end
  end

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    if (chk) begin
      score("rst_out0", int'(o0), 0);
      score("rst_vld0", int'(v0), 0);
      score("rst_rdy0", int'(rdy0), 1);
      score("rst_ovr0", int'(ov0), 0);
      score("rst_out1", int'(o1), 0);
      score("rst_vld1", int'(v1), 0);
      score("rst_rdy1", int'(rdy1), 1);
      score("rst_ovr1", int'(ov1), 0);
    end
  endtask

  task automatic strobe(
    input logic signed [N-1:0] v,
    input bit c0, input int e0,
    input bit c1, input int e1
  );
    score("rdy_idle", int'(rdy0 & rdy1), 1);
    sample = v;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    q0.push_back('{c0, e0, cyc + LAT});
    q1.push_back('{c1, e1, cyc + LAT});
    score("rdy_busy", int'(rdy0 | rdy1), 0);
    repeat (T + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int w;
    do_reset(1'b1);

    for (int j = 0; j < T; j++)
      strobe((j == 0) ? 16'sh4000 : 16'sh0000, 1'b1, IMP[j], 1'b1, 16384);

    do_reset(1'b0);
    strobe(16'sd1, 1'b1, 0, 1'b1, 1);

    do_reset(1'b0);
    for (int j = 0; j < T; j++)
      strobe(16'sh7FFF, j == T - 1, 32767, j >= 1, 32767);

    do_reset(1'b0);
    for (int j = 0; j < T; j++)
      strobe(16'sh8000, j == T - 1, -32768, j >= 1, -32768);

    // overrun: second strobe lands mid-MAC and is dropped
    do_reset(1'b0);
    @(negedge clk);
    base = nv0;
    #1;
    sample = 16'sh4000;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    q0.push_back('{1'b1, -40, cyc + LAT});
    q1.push_back('{1'b1, 16384, cyc + LAT});
    score("ovr_pre0", int'(ov0), 0);
    repeat (4) @(posedge clk);
    #1;
    sample = 16'sh7FFF;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    score("ovr_set0", int'(ov0), 1);
    score("ovr_set1", int'(ov1), 1);
    repeat (12) @(posedge clk);
    #1;
    strobe(16'sh0000, 1'b1, -150, 1'b1, 16384);
    @(negedge clk);
    #1;
    score("ovr_pulses", nv0 - base, 2);
    score("ovr_hold0", int'(ov0), 1);
    score("ovr_hold1", int'(ov1), 1);

    // reset 8 cycles into a computation, with a strobe on the reset edge
    do_reset(1'b0);
    sample = 16'sh7FFF;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample_valid = 1'b0;
    score("midrst_rdy", int'(rdy0 & rdy1), 1);
    repeat (20) @(posedge clk);
    #1;
    strobe(16'sh4000, 1'b1, -40, 1'b1, 16384);

    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    #1;
    score("drain0", q0.size(), 0);
    score("drain1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_decim_lpf.md
# fir_decim_lpf

Anti-aliasing low-pass FIR that sits directly upstream of the downsampler in the decimation chain. It accepts one signed N-bit sample per input strobe and runs a single time-shared multiply-accumulate over T taps. It emits one filtered, rounded and saturated N-bit sample per accepted input. The downsampler then keeps 1 of every M filtered samples.

## Interface
- N, 16, sample width (signed two's complement)
- T, 16, tap count (power of two, 4..64)
- C, 16, coefficient width (signed Q1.(C-1))
- COEF_SET, 0, coefficient table select: 0 = low-pass for M=4, 1 = saturation test set
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- sample  in  N  input sample
- sample_valid  in  1  one-cycle strobe, sample accepted when ready=1
- ready  out  1  high only in IDLE
- sample_out  out  N  filtered sample, held until next result
- out_valid  out  1  one-cycle pulse with each new sample_out
- overrun  out  1  sticky, set when sample_valid arrives while ready=0

## Operation
- State machine with three states: IDLE, MAC, DONE.
- IDLE: on sample_valid, shift the delay line so x[0]=sample and x[k]=x[k-1], clear acc, set k=0, go to MAC.
- MAC: each cycle acc += x[k]*h[k], k++. On the cycle where k==T-1, perform the last accumulate and go to DONE.
- DONE: form sample_out = sat_N((acc + 2^(C-2)) >>> (C-1)), pulse out_valid, go to IDLE.
- Rounding is round-half-up, using an arithmetic shift.
- Saturation clamps to [-2^(N-1), 2^(N-1)-1].
- Product width is N+C. Accumulator width is N+C+log2(T), so there is no internal overflow.
- sample_valid while ready=0: the sample is dropped, the delay line is untouched and overrun is set. overrun clears only on rst.
- The delay line is only ever shifted in IDLE, so a sample is never lost mid-computation.
- COEF_SET=0 table: symmetric, coefficient sum exactly 2^(C-1) (unity DC gain).
- COEF_SET=1 table: every tap 2^(C-1)-1.

## Timing
- Reset values: ready=1 (state IDLE), sample_out=0, out_valid=0, overrun=0, delay line=0, acc=0, k=0.
- rst asserted in any state returns to IDLE on the next edge. No out_valid is produced for the in-flight sample.
- Latency: sample_valid is sampled at edge E0. MAC occupies edges E1..ET. sample_out and out_valid are registered at edge E(T+1).
- ready falls after E0 and rises after E(T+1).
- Minimum input spacing is T+2 cycles; the next sample can be accepted at E(T+2).
- For default T=16: latency 17 cycles, throughput 1 sample per 18 cycles.
- out_valid is high for exactly one cycle per accepted sample. sample_out holds its value between pulses.
- rst and sample_valid in the same cycle: rst wins and the sample is not accepted.

## Structure
- Shared package fir_pkg holds:
  - coefficient tables for both COEF_SET values as constant arrays,
  - the state encoding,
  - the accumulator width function (N+C+clog2(T)),
  - a saturate function.
- One natural sub-module, fir_mac: registered multiplier plus accumulator with a clear input.
- The delay line, tap counter and FSM stay in the top module.

## Test plan
- Reset: drive rst for 2 cycles, then release.
  - Immediately after release: sample_out=0, out_valid=0, ready=1, overrun=0.
- Impulse response, COEF_SET=0, T=16:
  - Stimulus: sample 0x4000, then 15 zeros, spaced 18 cycles apart.
  - The k-th out_valid gives sample_out = round(h[k]/2). Each result arrives 17 cycles after its strobe.
- DC gain, COEF_SET=0:
  - Stimulus: 16 samples of 0x7FFF.
  - 16th output = 0x7FFF. Repeating with 0x8000 gives 0x8000 (-32768).
- Saturation, COEF_SET=1:
  - Stimulus: 16 samples of 0x7FFF; output = 0x7FFF (clamped).
  - Stimulus: 16 samples of 0x8000; output = 0x8000 (clamped).
- Overrun: strobe a sample, then strobe again 5 cycles later.
  - overrun rises and stays high.
  - Exactly one out_valid is produced.
  - The dropped value never appears in later outputs.
- Reset mid-MAC: assert rst 8 cycles after a strobe.
  - No out_valid is produced.
  - The delay line is zeroed: the next 0x4000 impulse reproduces the clean first-tap output.
